speed_calc: RTL and testbench



---
 rtl/bike_pkg.sv | 18 +
 rtl/seq_divider.sv | 57 +++++
 rtl/speed_calc.sv | 135 +++++++++++++
 tb/tb_speed_calc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// Shared constants for the bike computer: display width, clock, wheel geometry
// and the one-hot FSM encoding that control also uses.
package bike_pkg;

  localparam int SPEED_WIDTH = 7;
  localparam int CLK_HZ      = 1000;
  localparam int CIRC_MM     = 2130;
  // km/h * cycles: circumference (mm) * 3.6 * CLK_HZ / 1000
  localparam int NUM         = CIRC_MM * 36 * CLK_HZ / 10000;
  localparam int NUM_W       = $clog2(NUM + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_DIV  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. A load pulse starts
// NUM_W steps; done is high during the cycle whose edge performs the last step.
module seq_divider #(
  parameter int NUM_W = 13,
  parameter int PER_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [NUM_W-1:0] dividend,
  input  logic [PER_W-1:0] divisor,
  output logic [NUM_W-1:0] quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(NUM_W + 1);
  localparam logic [STEP_W-1:0] STEPS = STEP_W'(NUM_W);

  logic [PER_W:0]      r_rem;
  logic [NUM_W-1:0]    r_quo;
  logic [PER_W-1:0]    r_div;
  logic [STEP_W-1:0]   r_left;

  logic [PER_W:0]      w_rem_sh;
  logic                w_ge;
  logic [PER_W:0]      w_rem_nx;

  // Dividend bits enter the remainder MSB-first from the top of the quotient
  // register while quotient bits fill in from the bottom.
  assign w_rem_sh = {r_rem[PER_W-1:0], r_quo[NUM_W-1]};
  // A bit shifted out of the remainder means it already exceeds the divisor;
  // the modular subtraction below is still exact in that case.
  assign w_ge     = r_rem[PER_W] || (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;

  assign quotient = r_quo;
  assign done     = (r_left == STEP_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_left <= '0;
    end else if (load) begin
      r_rem  <= '0;
      r_quo  <= dividend;
      r_div  <= divisor;
      r_left <= STEPS;
    end else if (r_left != '0) begin
      r_rem  <= w_rem_nx;
      r_quo  <= {r_quo[NUM_W-2:0], w_ge};
      r_left <= r_left - STEP_W'(1);
    end
  end

endmodule

// File: rtl/speed_calc.sv
// Wheel-sensor conditioning, period measurement and on-demand km/h calculation
// feeding the control block.
module speed_calc #(
  parameter int SPEED_WIDTH = bike_pkg::SPEED_WIDTH,
  parameter int CLK_HZ      = bike_pkg::CLK_HZ,
  parameter int CIRC_MM     = bike_pkg::CIRC_MM,
  parameter int NUM         = CIRC_MM * 36 * CLK_HZ / 10000,
  parameter int NUM_W       = bike_pkg::NUM_W,
  parameter int PER_W       = 16,
  parameter int MIN_PERIOD  = 50,
  parameter int STOP_CYCLES = 3000,
  parameter int SPEED_MAX   = 99
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wheel_in,
  input  logic                   start,
  output logic [SPEED_WIDTH-1:0] speed,
  output logic                   valid,
  output logic                   busy,
  output logic                   wheel_tick
);

  localparam logic [PER_W-1:0]       MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]       STOP_P  = PER_W'(STOP_CYCLES);
  localparam logic [PER_W-1:0]       CNT_MAX = '1;
  localparam logic [NUM_W-1:0]       NUM_V   = NUM_W'(NUM);
  localparam logic [NUM_W-1:0]       SMAX_Q  = NUM_W'(SPEED_MAX);
  localparam logic [SPEED_WIDTH-1:0] SMAX_S  = SPEED_WIDTH'(SPEED_MAX);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;
  logic [PER_W-1:0]   r_cnt;
  logic [PER_W-1:0]   r_period;
  logic               r_have_period;
  logic               r_first_seen;
  bike_pkg::state_t   r_state;
  logic               r_zero;

  logic               w_rise;
  logic               w_accept;
  logic [PER_W-1:0]   w_div;
  logic               w_load;
  logic               w_div_done;
  logic [NUM_W-1:0]   w_quo;

  assign w_rise   = r_sync2 & ~r_sync3;
  // Lockout only applies once a period exists, so the very first edges after
  // a stop are never lost to a stale counter value.
  assign w_accept = w_rise && ((r_cnt >= MIN_P) || !r_have_period);
  // A long gap since the last edge lowers the reading while decelerating.
  assign w_div    = (r_period > r_cnt) ? r_period : r_cnt;
  assign w_load   = (r_state == bike_pkg::ST_IDLE) && start && r_have_period;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_cnt         <= '0;
      r_period      <= '0;
      r_have_period <= 1'b0;
      r_first_seen  <= 1'b0;
      wheel_tick    <= 1'b0;
    end else begin
      r_sync1    <= wheel_in;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      wheel_tick <= w_accept;
      if (w_accept) begin
        r_period <= r_cnt;
        r_cnt    <= PER_W'(1);
        if (r_first_seen) r_have_period <= 1'b1;
        else              r_first_seen  <= 1'b1;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + PER_W'(1);
        if (r_cnt == STOP_P) begin
          r_have_period <= 1'b0;
          r_first_seen  <= 1'b0;
        end
      end
    end
  end

  seq_divider #(
    .NUM_W (NUM_W),
    .PER_W (PER_W)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .dividend (NUM_V),
    .divisor  (w_div),
    .quotient (w_quo),
    .done     (w_div_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= bike_pkg::ST_IDLE;
      r_zero  <= 1'b0;
      speed   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        bike_pkg::ST_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_zero  <= !r_have_period;
            r_state <= r_have_period ? bike_pkg::ST_DIV : bike_pkg::ST_DONE;
          end
        end
        bike_pkg::ST_DIV: begin
          if (w_div_done) r_state <= bike_pkg::ST_DONE;
        end
        bike_pkg::ST_DONE: begin
          // Clamp on the full quotient so large values never wrap on truncation.
          speed   <= r_zero ? '0 :
                     ((w_quo > SMAX_Q) ? SMAX_S : w_quo[SPEED_WIDTH-1:0]);
          valid   <= 1'b1;
          busy    <= 1'b0;
          r_state <= bike_pkg::ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= bike_pkg::ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speed_calc.sv
// Bench for speed_calc: table-driven wheel trains, hand-written corner cases and
// a randomized phase, all checked every cycle against an edge-timing model.
module tb_speed_calc;

  localparam int NUM  = 2130 * 36 * 1000 / 10000;
  localparam int MINP = 50;
  localparam int STOP = 3000;
  localparam int SMAX = 99;
  localparam int LAT  = 14;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wheel_in = 1'b0;
  logic       start = 1'b0;
  logic [6:0] speed;
  logic       valid;
  logic       busy;
  logic       wheel_tick;

  always #5 clock = ~clock;

  speed_calc dut (
    .clock      (clock),
    .reset      (reset),
    .wheel_in   (wheel_in),
    .start      (start),
    .speed      (speed),
    .valid      (valid),
    .busy       (busy),
    .wheel_tick (wheel_tick)
  );

  typedef struct {
    int period;
    int exp_speed;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tick_cnt = 0;
  int valid_cnt = 0;

  // Reference state: wheel_in value sampled at each clock edge, plus the
  // edge-to-edge timing the sensor rules imply.
  bit w_hist [0:131071];
  int m_last   = 0;
  bit m_first  = 1'b0;
  bit m_have   = 1'b0;
  int m_period = 0;
  int m_done   = -1;
  int m_result = 0;
  int m_speed  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int elapsed(input int c);
    int e;
    e = c - m_last;
    return (e > 65535) ? 65535 : e;
  endfunction

  task automatic step();
    bit st, rs, e_tick;
    int c, el, dv;
    w_hist[cyc+1] = wheel_in;
    st = start;
    rs = reset;
    @(posedge clock);
    cyc++;
    #1;
    start = 1'b0;
    c = cyc;
    e_tick = 1'b0;
    if (rs) begin
      m_first = 0; m_have = 0; m_period = 0;
      m_last = c + 1; m_done = -1; m_speed = 0;
    end else begin
      if (c == m_done) m_speed = m_result;
      if (st && !(c <= m_done)) begin
        el = elapsed(c);
        if (m_have && el <= STOP) begin
          dv = (m_period > el) ? m_period : el;
          m_result = (NUM / dv > SMAX) ? SMAX : NUM / dv;
          m_done = c + LAT;
        end else begin
          m_result = 0;
          m_done = c + 1;
        end
      end
      if (c >= 3 && w_hist[c-2] && !w_hist[c-3]) begin
        el = elapsed(c);
        if (el > STOP) begin m_have = 0; m_first = 0; end
        if (el >= MINP || !m_have) begin
          e_tick = 1'b1;
          m_period = el;
          if (m_first) m_have = 1; else m_first = 1;
          m_last = c;
        end
      end
    end
    chk("wheel_tick", int'(wheel_tick), int'(e_tick));
    chk("valid", int'(valid), (!rs && c == m_done) ? 1 : 0);
    chk("busy", int'(busy), (m_done > c) ? 1 : 0);
    chk("speed", int'(speed), m_speed);
    tick_cnt += int'(wheel_tick);
    valid_cnt += int'(valid);
  endtask

  task automatic edge_train(input int p, input int n, input bit bounce);
    for (int e = 0; e < n; e++)
      for (int k = 0; k < p; k++) begin
        wheel_in = (k < 5) || (bounce && (k == 20 || k == 21));
        step();
      end
  endtask

  task automatic wait_valid(input string name, input int budget, output int lat);
    bit ok;
    ok = 1'b0;
    lat = 0;
    while (lat < budget && !ok) begin
      step();
      lat++;
      if (valid) ok = 1'b1;
    end
    chk({name, "_seen"}, int'(ok), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int lat, g, hi, bpos;
    bit bnc;

    tbl[0] = '{100, 76};
    tbl[1] = '{200, 38};
    tbl[2] = '{60, 99};
    tbl[3] = '{150, 51};
    tbl[4] = '{80, 95};

    repeat (3) step();
    chk("rst_speed", int'(speed), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(wheel_tick), 0);
    reset = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 5; i++) begin
      tick_cnt = 0;
      edge_train(tbl[i].period, 3, 1'b0);
      chk("tbl_ticks", tick_cnt, 3);
      start = 1'b1;
      step();
      wait_valid("tbl", 30, lat);
      chk("tbl_latency", lat, LAT);
      chk("tbl_speed", int'(speed), tbl[i].exp_speed);
      $display("txn period=%0d speed=%0d latency=%0d", tbl[i].period, speed, lat);
    end

    tick_cnt = 0;
    edge_train(60, 4, 1'b1);
    chk("bounce_ticks", tick_cnt, 4);
    start = 1'b1;
    step();
    wait_valid("bounce", 30, lat);
    chk("bounce_speed", int'(speed), 99);
    $display("txn bounce period=60 speed=%0d", speed);

    edge_train(100, 3, 1'b0);
    while (cyc < m_last + 249) step();
    start = 1'b1;
    step();
    wait_valid("decel", 30, lat);
    chk("decel_speed", int'(speed), 30);
    $display("txn decel cnt=250 speed=%0d", speed);

    repeat (3000) step();
    start = 1'b1;
    step();
    step();
    chk("stop_valid", int'(valid), 1);
    chk("stop_speed", int'(speed), 0);
    $display("txn stopped speed=%0d", speed);

    edge_train(3000, 3, 1'b0);
    start = 1'b1;
    step();
    wait_valid("stop_edge", 30, lat);
    chk("stop_edge_speed", int'(speed), 2);
    $display("txn period=3000 speed=%0d", speed);

    edge_train(100, 3, 1'b0);
    start = 1'b1;
    step();
    repeat (4) step();
    start = 1'b1;
    valid_cnt = 0;
    repeat (30) step();
    chk("dbl_start_valids", valid_cnt, 1);
    chk("dbl_start_speed", int'(speed), 76);
    $display("txn double start valids=%0d speed=%0d", valid_cnt, speed);

    edge_train(200, 3, 1'b0);
    start = 1'b1;
    step();
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("mid_rst_speed", int'(speed), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_tick", int'(wheel_tick), 0);
    reset = 1'b0;
    valid_cnt = 0;
    repeat (20) step();
    chk("mid_rst_no_valid", valid_cnt, 0);
    $display("txn reset mid-divide valids=%0d", valid_cnt);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0:       g = 2998 + $urandom_range(0, 4);
        1:       g = $urandom_range(12, 60);
        default: g = $urandom_range(40, 400);
      endcase
      hi = $urandom_range(2, 8);
      bnc = ($urandom_range(0, 3) == 0);
      bpos = $urandom_range(hi + 2, g - 2);
      for (int k = 0; k < g; k++) begin
        wheel_in = (k < hi) || (bnc && k == bpos);
        if ($urandom_range(0, 39) == 0) start = 1'b1;
        step();
      end
    end
    wheel_in = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
